// File: rtl/mux_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mux_rr_arbiter
//
// Round-robin arbiter that owns a shared one-bit channel. Four requesters
// compete for the channel. The winner's index drives a registered 4:1 mux
// select, and that requester's data bit appears on y. A grant lasts until
// one of two things happens:
//   - the owner drops its request, or
//   - the owner has held the channel for MAX_HOLD cycles while someone else
//     is waiting.
// On release the priority pointer moves just past the released owner.
// Ownership then passes to a waiting requester in the same cycle, so no
// idle cycle is inserted between grants.
//
// Parameters:
//   MAX_HOLD      longest grant (in cycles) while another requester waits,
//                 legal range 2..15
//
// Ports:
//   clk           single clock, rising edge
//   rst           synchronous, active-high reset
//   req0..req3    request lines, held high while the channel is wanted
//   d0..d3        data bit offered by each requester
//   s1,s0         registered mux select = index of the granted requester
//   gnt0..gnt3    registered one-hot grant, all low when idle
//   valid         high while a grant is active
//   y             selected data bit qualified by valid
// -----------------------------------------------------------------------------
module mux_rr_arbiter #(
    parameter int MAX_HOLD = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic req0,
    input  logic req1,
    input  logic req2,
    input  logic req3,
    input  logic d0,
    input  logic d1,
    input  logic d2,
    input  logic d3,
    output logic s1,
    output logic s0,
    output logic gnt0,
    output logic gnt1,
    output logic gnt2,
    output logic gnt3,
    output logic valid,
    output logic y
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

    state_t     state, state_n;
    logic [1:0] ptr, ptr_n;
    logic [3:0] hcnt, hcnt_n;
    logic [3:0] gnt, gnt_n;
    logic [1:0] sel, sel_n;

    logic [3:0] req_v;
    logic [3:0] d_v;
    logic [3:0] others;
    logic [2:0] win_any;
    logic [2:0] win_oth;
    logic       release_now;

    assign req_v = {req3, req2, req1, req0};
    assign d_v   = {d3, d2, d1, d0};

    // Returns {found, index}. The search starts at pointer p and wraps
    // around. The loop runs from the farthest offset down to the nearest
    // one, so the requester closest to p is written last and wins.
    function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] p);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            idx = p + 2'(i);
            if (r[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    // The current owner is removed from the waiting set. Because of this,
    // a handover can never select the requester that is being released.
    assign others  = req_v & ~(4'b0001 << sel);
    assign win_any = pick(req_v, ptr);
    assign win_oth = pick(others, sel + 2'd1);

    // Next-state logic. A release is checked only while a grant is active.
    // The successor is searched from the already-advanced pointer, so a
    // requester that was forcibly rotated out ends up last in line.
    always_comb begin
        state_n     = state;
        ptr_n       = ptr;
        hcnt_n      = hcnt;
        gnt_n       = gnt;
        sel_n       = sel;
        release_now = 1'b0;

        case (state)
            IDLE: begin
                if (win_any[2]) begin
                    state_n = GRANT;
                    sel_n   = win_any[1:0];
                    gnt_n   = 4'b0001 << win_any[1:0];
                    hcnt_n  = 4'd0;
                end
            end
            GRANT: begin
                release_now = !req_v[sel] || ((hcnt == HOLD_LAST) && (|others));
                if (release_now) begin
                    ptr_n = sel + 2'd1;
                    if (win_oth[2]) begin
                        sel_n  = win_oth[1:0];
                        gnt_n  = 4'b0001 << win_oth[1:0];
                        hcnt_n = 4'd0;
                    end else begin
                        state_n = IDLE;
                        gnt_n   = 4'b0000;
                    end
                end else if (hcnt != HOLD_LAST) begin
                    hcnt_n = hcnt + 4'd1;
                end
            end
            default: begin
                state_n = IDLE;
                gnt_n   = 4'b0000;
            end
        endcase
    end

    // State register. Reset takes priority over everything, including an
    // active grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= 2'd0;
            hcnt  <= 4'd0;
            gnt   <= 4'b0000;
            sel   <= 2'd0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            hcnt  <= hcnt_n;
            gnt   <= gnt_n;
            sel   <= sel_n;
        end
    end

    assign valid = (state == GRANT);
    assign {s1, s0} = sel;
    assign {gnt3, gnt2, gnt1, gnt0} = gnt;
    assign y = d_v[sel] & valid;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mux_rr_arbiter
//
// Testbench for mux_rr_arbiter. Each step drives the inputs on the falling
// edge and advances a small behavioural reference model. The model's
// expected outputs are pushed onto a scoreboard queue. After the next
// rising edge the outputs are sampled, and the queue entry is popped and
// compared. Directed scenarios add fixed expected values on top of the
// model comparison.
// -----------------------------------------------------------------------------
module tb_mux_rr_arbiter;

    localparam int MAX_HOLD = 4;

    typedef struct packed {
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       valid;
        logic       y;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req_v = 4'b0000;
    logic [3:0] d_v = 4'b0000;
    logic [3:0] gnt_v;
    logic       s1, s0;
    logic       valid, y;
    logic [1:0] sel_v;

    exp_t sb_q[$];

    int compared = 0;
    int mismatched = 0;

    int   m_busy = 0;
    int   m_sel = 0;
    int   m_ptr = 0;
    int   m_cnt = 0;

    assign sel_v = {s1, s0};

    always #5 clk = ~clk;

    mux_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk  (clk),
        .rst  (rst),
        .req0 (req_v[0]),
        .req1 (req_v[1]),
        .req2 (req_v[2]),
        .req3 (req_v[3]),
        .d0   (d_v[0]),
        .d1   (d_v[1]),
        .d2   (d_v[2]),
        .d3   (d_v[3]),
        .s1   (s1),
        .s0   (s0),
        .gnt0 (gnt_v[0]),
        .gnt1 (gnt_v[1]),
        .gnt2 (gnt_v[2]),
        .gnt3 (gnt_v[3]),
        .valid(valid),
        .y    (y)
    );

    // One comparison: counts it, and reports the tag with observed and
    // expected values when they differ.
    task automatic compareValue(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // First requester with its request high, searching from p with
    // wrap-around. Returns -1 when nobody is requesting.
    function automatic int firstFrom(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++) begin
            int i;
            i = (p + k) % 4;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    // Reference behaviour for one rising edge with the given inputs.
    task automatic modelStep(input logic r_rst, input logic [3:0] r);
        int w;
        logic [3:0] oth;
        if (r_rst) begin
            m_busy = 0; m_ptr = 0; m_cnt = 0; m_sel = 0;
        end else if (m_busy == 0) begin
            w = firstFrom(r, m_ptr);
            if (w >= 0) begin
                m_busy = 1; m_sel = w; m_cnt = 0;
            end
        end else begin
            oth = r;
            oth[m_sel] = 1'b0;
            if (!r[m_sel] || (m_cnt == MAX_HOLD - 1 && oth != 4'b0000)) begin
                m_ptr = (m_sel + 1) % 4;
                w = firstFrom(oth, m_ptr);
                if (w >= 0) begin
                    m_sel = w; m_cnt = 0;
                end else begin
                    m_busy = 0;
                end
            end else if (m_cnt < MAX_HOLD - 1) begin
                m_cnt++;
            end
        end
    endtask

    // Drives the inputs on the falling edge, advances the model and queues
    // the outputs expected after the next rising edge.
    task automatic applyStimulus(input logic r_rst, input logic [3:0] r, input logic [3:0] d);
        exp_t e;
        @(negedge clk);
        rst   = r_rst;
        req_v = r;
        d_v   = d;
        modelStep(r_rst, r);
        e.gnt   = (m_busy != 0) ? 4'(1 << m_sel) : 4'b0000;
        e.sel   = 2'(m_sel);
        e.valid = (m_busy != 0);
        e.y     = (m_busy != 0) && d[m_sel];
        sb_q.push_back(e);
    endtask

    // Samples just after the rising edge and checks the outputs against the
    // oldest queued expectation, plus the structural invariants.
    task automatic checkOutput();
        exp_t e;
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            compareValue("sb_empty", 8'd0, 8'd1);
        end else begin
            e = sb_q.pop_front();
            compareValue("gnt",   8'(gnt_v), 8'(e.gnt));
            compareValue("sel",   8'(sel_v), 8'(e.sel));
            compareValue("valid", 8'(valid), 8'(e.valid));
            compareValue("y",     8'(y),     8'(e.y));
        end
        compareValue("onehot0", 8'($onehot0(gnt_v)), 8'd1);
        if (valid) begin
            compareValue("sel_vs_gnt", 8'(gnt_v), 8'(4'b0001 << sel_v));
        end
        compareValue("y_vs_d", 8'(y), 8'(d_v[sel_v] & valid));
    endtask

    task automatic cycle(input logic r_rst, input logic [3:0] r, input logic [3:0] d);
        applyStimulus(r_rst, r, d);
        checkOutput();
    endtask

    initial begin
        logic [3:0] rnd_req;
        int idx;

        // Reset state
        cycle(1'b1, 4'b0000, 4'b0000);
        cycle(1'b1, 4'b1111, 4'b1111);
        compareValue("rst_gnt",   8'(gnt_v), 8'h00);
        compareValue("rst_sel",   8'(sel_v), 8'h00);
        compareValue("rst_valid", 8'(valid), 8'h00);
        compareValue("rst_y",     8'(y),     8'h00);

        // Single requester 2, then release to idle
        cycle(1'b0, 4'b0100, 4'b0100);
        compareValue("r2_gnt",   8'(gnt_v), 8'h04);
        compareValue("r2_sel",   8'(sel_v), 8'h02);
        compareValue("r2_valid", 8'(valid), 8'h01);
        compareValue("r2_y",     8'(y),     8'h01);
        cycle(1'b0, 4'b0000, 4'b0100);
        compareValue("r2_idle_valid", 8'(valid), 8'h00);
        compareValue("r2_idle_y",     8'(y),     8'h00);
        compareValue("r2_idle_sel",   8'(sel_v), 8'h02);

        // All four requesting: back-to-back rotation, MAX_HOLD cycles each
        cycle(1'b1, 4'b0000, 4'b0000);
        for (int k = 0; k < 20; k++) begin
            cycle(1'b0, 4'b1111, 4'b0101);
            idx = (k / 4) % 4;
            compareValue("rot_gnt",   8'(gnt_v), 8'(4'b0001 << idx));
            compareValue("rot_valid", 8'(valid), 8'h01);
            compareValue("rot_y",     8'(y),     8'((idx % 2) == 0));
        end

        // Lone requester keeps the grant past saturation; the pointer moves
        // only when it releases
        cycle(1'b1, 4'b0000, 4'b0000);
        for (int k = 0; k < 20; k++) begin
            cycle(1'b0, 4'b0010, 4'b0010);
            compareValue("hold_gnt", 8'(gnt_v), 8'h02);
        end
        cycle(1'b0, 4'b0000, 4'b0000);
        compareValue("hold_rel_valid", 8'(valid), 8'h00);
        cycle(1'b0, 4'b0101, 4'b1111);
        compareValue("hold_ptr_gnt", 8'(gnt_v), 8'h04);

        // Owner drops while another rises on the same edge: direct handover
        cycle(1'b1, 4'b0000, 4'b0000);
        cycle(1'b0, 4'b0001, 4'b1001);
        compareValue("ho_gnt0", 8'(gnt_v), 8'h01);
        cycle(1'b0, 4'b1000, 4'b1001);
        compareValue("ho_gnt3", 8'(gnt_v), 8'h08);
        compareValue("ho_sel3", 8'(sel_v), 8'h03);
        compareValue("ho_y",    8'(y),     8'h01);

        // Reset in the middle of the grant to requester 2
        cycle(1'b1, 4'b0000, 4'b0000);
        for (int k = 0; k < 9; k++) begin
            cycle(1'b0, 4'b1111, 4'b1111);
        end
        compareValue("mr_pre_gnt2", 8'(gnt_v), 8'h04);
        cycle(1'b1, 4'b1111, 4'b1111);
        compareValue("mr_gnt",   8'(gnt_v), 8'h00);
        compareValue("mr_sel",   8'(sel_v), 8'h00);
        compareValue("mr_valid", 8'(valid), 8'h00);
        cycle(1'b0, 4'b1111, 4'b1111);
        compareValue("mr_first_gnt0", 8'(gnt_v), 8'h01);

        // Random traffic against the model
        cycle(1'b1, 4'b0000, 4'b0000);
        rnd_req = 4'b0000;
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 3) == 0) rnd_req = 4'($urandom_range(0, 15));
            cycle(($urandom_range(0, 59) == 0), rnd_req, 4'($urandom_range(0, 15)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
